// File: rtl/rs_branch.sv
//-----------------------------------------------------------------------------
// rs_branch
// In-order reservation station for conditional branches (BEQ/BNE/BLT/BGE/
// BLTU/BGEU).
//
// Branch uops are queued in allocation order. Pending operands are woken up
// by snooping the ALU and load/store result broadcast buses (CDBs). The
// oldest entry issues to the branch execute stage once both of its operands
// are resolved. Younger ready entries never pass a stalled head, so execute
// always sees branches in program order.
//
// Optional build macro:
//   RS_BRANCH_HEAD_BYPASS_EN  - the head may also issue in the same cycle
//                               its last operand appears on a CDB. The CDB
//                               data is forwarded straight into the issue
//                               register.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   rdy                          global ready; low freezes all state
//   flush_in                     drop every queued entry
//   alloc_en_in, alloc_*_in      allocate one branch uop
//   full_out                     queue full; allocation is ignored while high
//   cdb_alu_*_in, cdb_lsb_*_in   ALU and load/store result broadcasts
//   branch_busy_out              one-cycle issue strobe
//   branch_*_out, pc_out,
//   offset_out                   fields of the issued branch
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef RS_BRANCH_TYPES
`define RS_BRANCH_TYPES
`define SINST_T  logic [5:0]
`define ADDR_T   logic [31:0]
`define WORD_T   logic [31:0]
`define REGTAG_T logic [4:0]
`define UNLOCKED 5'd0
`define ZERO     32'd0
`endif

module rs_branch #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     flush_in,

  input  logic     alloc_en_in,
  input  `SINST_T  alloc_op_in,
  input  `ADDR_T   alloc_pc_in,
  input  `WORD_T   alloc_offset_in,
  input  `REGTAG_T alloc_tagx_in,
  input  `REGTAG_T alloc_tagy_in,
  input  `WORD_T   alloc_datax_in,
  input  `WORD_T   alloc_datay_in,
  output logic     full_out,

  input  logic     cdb_alu_en_in,
  input  `REGTAG_T cdb_alu_tag_in,
  input  `WORD_T   cdb_alu_data_in,
  input  logic     cdb_lsb_en_in,
  input  `REGTAG_T cdb_lsb_tag_in,
  input  `WORD_T   cdb_lsb_data_in,

  output logic     branch_busy_out,
  output `SINST_T  branch_op_out,
  output `ADDR_T   pc_out,
  output `WORD_T   offset_out,
  output `REGTAG_T branch_tagx_out,
  output `REGTAG_T branch_tagy_out,
  output `WORD_T   branch_datax_out,
  output `WORD_T   branch_datay_out
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  // Entry storage
  `SINST_T  op_q    [DEPTH];
  `ADDR_T   pc_q    [DEPTH];
  `WORD_T   off_q   [DEPTH];
  `REGTAG_T tagx_q  [DEPTH];
  `REGTAG_T tagy_q  [DEPTH];
  `WORD_T   datax_q [DEPTH];
  `WORD_T   datay_q [DEPTH];

  // Operand state after this cycle's wakeup
  `REGTAG_T tagx_n  [DEPTH];
  `REGTAG_T tagy_n  [DEPTH];
  `WORD_T   datax_n [DEPTH];
  `WORD_T   datay_n [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] offs;

  `REGTAG_T alloc_tagx;
  `REGTAG_T alloc_tagy;
  `WORD_T   alloc_datax;
  `WORD_T   alloc_datay;

  `REGTAG_T head_tagx;
  `REGTAG_T head_tagy;
  `WORD_T   head_datax;
  `WORD_T   head_datay;
  logic     head_ready;

  logic alloc_ok;
  logic issue;

  // An UNLOCKED tag never matches a broadcast, even one carrying that value.
  function automatic logic cdb_match(input `REGTAG_T tag, input logic en,
                                     input `REGTAG_T cdb_tag);
    return en && (tag != `UNLOCKED) && (tag == cdb_tag);
  endfunction

  assign full_out = (count_q == DEPTH_CNT);
  assign alloc_ok = rdy && !flush_in && alloc_en_in && !full_out;
  assign issue    = rdy && !flush_in && head_ready;

  // Wakeup of queued entries. An entry is valid when its distance from head
  // is below count; this also covers the full case where head == tail.
  always_comb begin
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs       = PTR_W'(i) - head_q;
      valid[i]   = ({1'b0, offs} < count_q);
      tagx_n[i]  = tagx_q[i];
      tagy_n[i]  = tagy_q[i];
      datax_n[i] = datax_q[i];
      datay_n[i] = datay_q[i];
      if (valid[i]) begin
        // ALU wins if both buses ever matched the same tag.
        if (cdb_match(tagx_q[i], cdb_alu_en_in, cdb_alu_tag_in)) begin
          tagx_n[i]  = `UNLOCKED;
          datax_n[i] = cdb_alu_data_in;
        end else if (cdb_match(tagx_q[i], cdb_lsb_en_in, cdb_lsb_tag_in)) begin
          tagx_n[i]  = `UNLOCKED;
          datax_n[i] = cdb_lsb_data_in;
        end
        if (cdb_match(tagy_q[i], cdb_alu_en_in, cdb_alu_tag_in)) begin
          tagy_n[i]  = `UNLOCKED;
          datay_n[i] = cdb_alu_data_in;
        end else if (cdb_match(tagy_q[i], cdb_lsb_en_in, cdb_lsb_tag_in)) begin
          tagy_n[i]  = `UNLOCKED;
          datay_n[i] = cdb_lsb_data_in;
        end
      end
    end
  end

  // Same-cycle capture for the entry being allocated.
  always_comb begin
    alloc_tagx  = alloc_tagx_in;
    alloc_datax = alloc_datax_in;
    alloc_tagy  = alloc_tagy_in;
    alloc_datay = alloc_datay_in;
    if (cdb_match(alloc_tagx_in, cdb_alu_en_in, cdb_alu_tag_in)) begin
      alloc_tagx  = `UNLOCKED;
      alloc_datax = cdb_alu_data_in;
    end else if (cdb_match(alloc_tagx_in, cdb_lsb_en_in, cdb_lsb_tag_in)) begin
      alloc_tagx  = `UNLOCKED;
      alloc_datax = cdb_lsb_data_in;
    end
    if (cdb_match(alloc_tagy_in, cdb_alu_en_in, cdb_alu_tag_in)) begin
      alloc_tagy  = `UNLOCKED;
      alloc_datay = cdb_alu_data_in;
    end else if (cdb_match(alloc_tagy_in, cdb_lsb_en_in, cdb_lsb_tag_in)) begin
      alloc_tagy  = `UNLOCKED;
      alloc_datay = cdb_lsb_data_in;
    end
  end

  // Head readiness. By default only the stored state counts; the bypass
  // build also accepts an operand arriving on a CDB this very cycle.
  always_comb begin
    head_tagx  = tagx_q[head_q];
    head_tagy  = tagy_q[head_q];
    head_datax = datax_q[head_q];
    head_datay = datay_q[head_q];
`ifdef RS_BRANCH_HEAD_BYPASS_EN
    if (cdb_match(head_tagx, cdb_alu_en_in, cdb_alu_tag_in)) begin
      head_tagx  = `UNLOCKED;
      head_datax = cdb_alu_data_in;
    end else if (cdb_match(head_tagx, cdb_lsb_en_in, cdb_lsb_tag_in)) begin
      head_tagx  = `UNLOCKED;
      head_datax = cdb_lsb_data_in;
    end
    if (cdb_match(head_tagy, cdb_alu_en_in, cdb_alu_tag_in)) begin
      head_tagy  = `UNLOCKED;
      head_datay = cdb_alu_data_in;
    end else if (cdb_match(head_tagy, cdb_lsb_en_in, cdb_lsb_tag_in)) begin
      head_tagy  = `UNLOCKED;
      head_datay = cdb_lsb_data_in;
    end
`endif
    head_ready = (count_q != '0) && (head_tagx == `UNLOCKED) &&
                 (head_tagy == `UNLOCKED);
  end

  // Entry array. A flush leaves stale contents behind; they are invalid
  // because count is zero and are overwritten on the next allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        pc_q[i]    <= `ZERO;
        off_q[i]   <= `ZERO;
        tagx_q[i]  <= `UNLOCKED;
        tagy_q[i]  <= `UNLOCKED;
        datax_q[i] <= `ZERO;
        datay_q[i] <= `ZERO;
      end
    end else if (rdy && !flush_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        tagx_q[i]  <= tagx_n[i];
        tagy_q[i]  <= tagy_n[i];
        datax_q[i] <= datax_n[i];
        datay_q[i] <= datay_n[i];
      end
      if (alloc_ok) begin
        op_q[tail_q]    <= alloc_op_in;
        pc_q[tail_q]    <= alloc_pc_in;
        off_q[tail_q]   <= alloc_offset_in;
        tagx_q[tail_q]  <= alloc_tagx;
        tagy_q[tail_q]  <= alloc_tagy;
        datax_q[tail_q] <= alloc_datax;
        datay_q[tail_q] <= alloc_datay;
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (flush_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (alloc_ok) tail_q <= tail_q + 1'b1;
        if (issue)    head_q <= head_q + 1'b1;
        case ({alloc_ok, issue})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Issue register. Any cycle without an issue (including stalls and
  // flushes) presents zeros with busy low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_busy_out  <= 1'b0;
      branch_op_out    <= '0;
      pc_out           <= `ZERO;
      offset_out       <= `ZERO;
      branch_tagx_out  <= `UNLOCKED;
      branch_tagy_out  <= `UNLOCKED;
      branch_datax_out <= `ZERO;
      branch_datay_out <= `ZERO;
    end else if (issue) begin
      branch_busy_out  <= 1'b1;
      branch_op_out    <= op_q[head_q];
      pc_out           <= pc_q[head_q];
      offset_out       <= off_q[head_q];
      branch_tagx_out  <= `UNLOCKED;
      branch_tagy_out  <= `UNLOCKED;
      branch_datax_out <= head_datax;
      branch_datay_out <= head_datay;
    end else begin
      branch_busy_out  <= 1'b0;
      branch_op_out    <= '0;
      pc_out           <= `ZERO;
      offset_out       <= `ZERO;
      branch_tagx_out  <= `UNLOCKED;
      branch_tagy_out  <= `UNLOCKED;
      branch_datax_out <= `ZERO;
      branch_datay_out <= `ZERO;
    end
  end

endmodule

// File: tb/tb_rs_branch.sv
//-----------------------------------------------------------------------------
// tb_rs_branch
// Self-checking bench for rs_branch: a table of single-cycle vectors,
// hand-written multi-cycle sequences, then randomized traffic compared with a
// queue-based reference model of the reservation station.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rs_branch;

  localparam logic [4:0] UNL = 5'd0;
`ifdef RS_BRANCH_HEAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush_in;
  logic        alloc_en_in;
  logic [5:0]  alloc_op_in;
  logic [31:0] alloc_pc_in;
  logic [31:0] alloc_offset_in;
  logic [4:0]  alloc_tagx_in;
  logic [4:0]  alloc_tagy_in;
  logic [31:0] alloc_datax_in;
  logic [31:0] alloc_datay_in;
  logic        full_out;
  logic        cdb_alu_en_in;
  logic [4:0]  cdb_alu_tag_in;
  logic [31:0] cdb_alu_data_in;
  logic        cdb_lsb_en_in;
  logic [4:0]  cdb_lsb_tag_in;
  logic [31:0] cdb_lsb_data_in;
  logic        branch_busy_out;
  logic [5:0]  branch_op_out;
  logic [31:0] pc_out;
  logic [31:0] offset_out;
  logic [4:0]  branch_tagx_out;
  logic [4:0]  branch_tagy_out;
  logic [31:0] branch_datax_out;
  logic [31:0] branch_datay_out;

  int n_checks = 0;
  int n_errors = 0;

  rs_branch #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_in(flush_in),
    .alloc_en_in(alloc_en_in), .alloc_op_in(alloc_op_in),
    .alloc_pc_in(alloc_pc_in), .alloc_offset_in(alloc_offset_in),
    .alloc_tagx_in(alloc_tagx_in), .alloc_tagy_in(alloc_tagy_in),
    .alloc_datax_in(alloc_datax_in), .alloc_datay_in(alloc_datay_in),
    .full_out(full_out),
    .cdb_alu_en_in(cdb_alu_en_in), .cdb_alu_tag_in(cdb_alu_tag_in),
    .cdb_alu_data_in(cdb_alu_data_in),
    .cdb_lsb_en_in(cdb_lsb_en_in), .cdb_lsb_tag_in(cdb_lsb_tag_in),
    .cdb_lsb_data_in(cdb_lsb_data_in),
    .branch_busy_out(branch_busy_out), .branch_op_out(branch_op_out),
    .pc_out(pc_out), .offset_out(offset_out),
    .branch_tagx_out(branch_tagx_out), .branch_tagy_out(branch_tagy_out),
    .branch_datax_out(branch_datax_out), .branch_datay_out(branch_datay_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  //---------------------------------------------------------------------------
  // Checking helpers
  //---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic b, input logic [5:0] op,
                         input logic [31:0] pc, input logic [31:0] off,
                         input logic [31:0] dx, input logic [31:0] dy);
    chk({name, ".busy"}, 32'(branch_busy_out), 32'(b));
    chk({name, ".op"},   32'(branch_op_out),   32'(op));
    chk({name, ".pc"},   pc_out,               pc);
    chk({name, ".off"},  offset_out,           off);
    chk({name, ".dx"},   branch_datax_out,     dx);
    chk({name, ".dy"},   branch_datay_out,     dy);
    chk({name, ".tagx"}, 32'(branch_tagx_out), 32'(UNL));
    chk({name, ".tagy"}, 32'(branch_tagy_out), 32'(UNL));
  endtask

  task automatic chk_idle(input string name);
    chk_out(name, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  //---------------------------------------------------------------------------
  // Drive helpers
  //---------------------------------------------------------------------------
  task automatic idle_in();
    rdy = 1'b1; flush_in = 1'b0; alloc_en_in = 1'b0;
    alloc_op_in = '0; alloc_pc_in = '0; alloc_offset_in = '0;
    alloc_tagx_in = UNL; alloc_tagy_in = UNL;
    alloc_datax_in = '0; alloc_datay_in = '0;
    cdb_alu_en_in = 1'b0; cdb_alu_tag_in = '0; cdb_alu_data_in = '0;
    cdb_lsb_en_in = 1'b0; cdb_lsb_tag_in = '0; cdb_lsb_data_in = '0;
  endtask

  task automatic drive_alloc(input logic [5:0] op, input logic [31:0] pc,
                             input logic [31:0] off, input logic [4:0] tx,
                             input logic [4:0] ty, input logic [31:0] dx,
                             input logic [31:0] dy);
    alloc_en_in = 1'b1; alloc_op_in = op; alloc_pc_in = pc;
    alloc_offset_in = off; alloc_tagx_in = tx; alloc_tagy_in = ty;
    alloc_datax_in = dx; alloc_datay_in = dy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  //---------------------------------------------------------------------------
  // Reference model: a queue of branches in allocation order
  //---------------------------------------------------------------------------
  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] off;
    logic [4:0]  tx;
    logic [4:0]  ty;
    logic [31:0] dx;
    logic [31:0] dy;
  } ent_t;

  ent_t mq[$];
  logic m_busy;
  ent_t m_out;

  function automatic ent_t wake(input ent_t e);
    ent_t r = e;
    if (r.tx != UNL && cdb_alu_en_in && r.tx == cdb_alu_tag_in) begin
      r.tx = UNL; r.dx = cdb_alu_data_in;
    end else if (r.tx != UNL && cdb_lsb_en_in && r.tx == cdb_lsb_tag_in) begin
      r.tx = UNL; r.dx = cdb_lsb_data_in;
    end
    if (r.ty != UNL && cdb_alu_en_in && r.ty == cdb_alu_tag_in) begin
      r.ty = UNL; r.dy = cdb_alu_data_in;
    end else if (r.ty != UNL && cdb_lsb_en_in && r.ty == cdb_lsb_tag_in) begin
      r.ty = UNL; r.dy = cdb_lsb_data_in;
    end
    return r;
  endfunction

  // Predicts the registered outputs after the coming edge from current inputs.
  task automatic model_step();
    ent_t h;
    ent_t e;
    bit   go;
    bit   was_full;
    m_busy = 1'b0;
    m_out  = '{op: '0, pc: '0, off: '0, tx: UNL, ty: UNL, dx: '0, dy: '0};
    if (!rdy) return;
    if (flush_in) begin
      mq.delete();
      return;
    end
    was_full = (mq.size() == 4);
    go = 1'b0;
    if (mq.size() != 0) begin
      h = mq[0];
      if (BYP) h = wake(h);
      go = (h.tx == UNL) && (h.ty == UNL);
    end
    foreach (mq[i]) mq[i] = wake(mq[i]);
    if (go) begin
      m_busy = 1'b1;
      m_out  = h;
      void'(mq.pop_front());
    end
    if (alloc_en_in && !was_full) begin
      e = '{op: alloc_op_in, pc: alloc_pc_in, off: alloc_offset_in,
            tx: alloc_tagx_in, ty: alloc_tagy_in,
            dx: alloc_datax_in, dy: alloc_datay_in};
      mq.push_back(wake(e));
    end
  endtask

  //---------------------------------------------------------------------------
  // Vector table
  //---------------------------------------------------------------------------
  typedef struct {
    logic        al;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] off;
    logic [4:0]  tx;
    logic [4:0]  ty;
    logic [31:0] dx;
    logic [31:0] dy;
    logic        ae;
    logic [4:0]  at;
    logic [31:0] ad;
    logic        le;
    logic [4:0]  lt;
    logic [31:0] ld;
    logic        eb;
    logic [5:0]  eop;
    logic [31:0] epc;
    logic [31:0] eoff;
    logic [31:0] edx;
    logic [31:0] edy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(
      input logic al, input logic [5:0] op, input logic [31:0] pc,
      input logic [31:0] off, input logic [4:0] tx, input logic [4:0] ty,
      input logic [31:0] dx, input logic [31:0] dy,
      input logic ae, input logic [4:0] at, input logic [31:0] ad,
      input logic le, input logic [4:0] lt, input logic [31:0] ld,
      input logic eb, input logic [5:0] eop, input logic [31:0] epc,
      input logic [31:0] eoff, input logic [31:0] edx, input logic [31:0] edy);
    vec_t v;
    v.al = al; v.op = op; v.pc = pc; v.off = off; v.tx = tx; v.ty = ty;
    v.dx = dx; v.dy = dy; v.ae = ae; v.at = at; v.ad = ad;
    v.le = le; v.lt = lt; v.ld = ld; v.eb = eb; v.eop = eop; v.epc = epc;
    v.eoff = eoff; v.edx = edx; v.edy = edy;
    return v;
  endfunction

  function automatic vec_t idle_row(input logic eb, input logic [5:0] eop,
                                    input logic [31:0] epc, input logic [31:0] eoff,
                                    input logic [31:0] edx, input logic [31:0] edy);
    return row(0, 0, 0, 0, UNL, UNL, 0, 0, 0, 0, 0, 0, 0, 0,
               eb, eop, epc, eoff, edx, edy);
  endfunction

  //---------------------------------------------------------------------------
  // Test sequence
  //---------------------------------------------------------------------------
  initial begin
    int          hit_pc[$];
    int          hit_cyc[$];
    int          first;
    logic [4:0]  t;

    idle_in();
    rst = 1'b1;
    #3;
    chk_idle("reset");
    chk("reset.full", 32'(full_out), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Ready alloc, same-cycle LSB capture, back-to-back issue, ALU capture,
    // and a broadcast on the UNLOCKED tag value that must not be captured.
    vecs.push_back(row(1, 6'd0, 32'h100, 32'h20, UNL, UNL, 32'h1, 32'h2,
                       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle_row(1, 6'd0, 32'h100, 32'h20, 32'h1, 32'h2));
    vecs.push_back(idle_row(0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 6'd5, 32'h200, 32'hFFFF_FFF0, UNL, 5'd9, 32'h3, 32'hDEAD,
                       0, 0, 0, 1, 5'd9, 32'h42, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle_row(1, 6'd5, 32'h200, 32'hFFFF_FFF0, 32'h3, 32'h42));
    vecs.push_back(idle_row(0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 6'd1, 32'h300, 32'h8, UNL, UNL, 32'h10, 32'h11,
                       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 6'd2, 32'h304, 32'hC, UNL, UNL, 32'h12, 32'h13,
                       0, 0, 0, 0, 0, 0, 1, 6'd1, 32'h300, 32'h8, 32'h10, 32'h11));
    vecs.push_back(idle_row(1, 6'd2, 32'h304, 32'hC, 32'h12, 32'h13));
    vecs.push_back(idle_row(0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 6'd3, 32'h308, 32'h4, 5'd6, UNL, 32'h0, 32'h5,
                       1, 5'd6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle_row(1, 6'd3, 32'h308, 32'h4, 32'h66, 32'h5));
    vecs.push_back(row(1, 6'd0, 32'h30C, 32'h0, UNL, UNL, 32'h77, 32'h88,
                       1, UNL, 32'hBAD, 1, UNL, 32'hBAD, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle_row(1, 6'd0, 32'h30C, 32'h0, 32'h77, 32'h88));
    vecs.push_back(idle_row(0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      idle_in();
      if (vecs[i].al)
        drive_alloc(vecs[i].op, vecs[i].pc, vecs[i].off, vecs[i].tx,
                    vecs[i].ty, vecs[i].dx, vecs[i].dy);
      cdb_alu_en_in = vecs[i].ae; cdb_alu_tag_in = vecs[i].at; cdb_alu_data_in = vecs[i].ad;
      cdb_lsb_en_in = vecs[i].le; cdb_lsb_tag_in = vecs[i].lt; cdb_lsb_data_in = vecs[i].ld;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].eb, vecs[i].eop, vecs[i].epc,
              vecs[i].eoff, vecs[i].edx, vecs[i].edy);
      chk($sformatf("vec%0d.full", i), 32'(full_out), 32'd0);
    end

    // Wakeup: BLT waits on tag 5, ALU broadcasts it two cycles later.
    idle_in();
    drive_alloc(6'd4, 32'h500, 32'h40, 5'd5, UNL, 32'h0, 32'h7);
    tick(); idle_in();
    chk_idle("wake.e0");
    tick(); chk_idle("wake.e1");
    tick(); chk_idle("wake.e2");
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 5'd5; cdb_alu_data_in = 32'hFFFF_FFFF;
    tick(); idle_in();
    chk_out("wake.e3", BYP, BYP ? 6'd4 : 6'd0, BYP ? 32'h500 : 32'h0,
            BYP ? 32'h40 : 32'h0, BYP ? 32'hFFFF_FFFF : 32'h0, BYP ? 32'h7 : 32'h0);
    tick();
    chk_out("wake.e4", !BYP, !BYP ? 6'd4 : 6'd0, !BYP ? 32'h500 : 32'h0,
            !BYP ? 32'h40 : 32'h0, !BYP ? 32'hFFFF_FFFF : 32'h0, !BYP ? 32'h7 : 32'h0);
    tick(); chk_idle("wake.e5");

    // In-order / full: stalled head on tag 3, three ready entries behind it.
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    drive_alloc(6'd0, 32'h600, 32'h0, 5'd3, UNL, 32'h0, 32'h1);
    tick(); chk_idle("full.a0");
    for (int k = 1; k < 4; k++) begin
      drive_alloc(6'(k), 32'h600 + 32'(4 * k), 32'h0, UNL, UNL, 32'(k), 32'(k));
      tick();
      chk_idle($sformatf("full.a%0d", k));
    end
    chk("full.flag", 32'(full_out), 32'd1);
    drive_alloc(6'd9, 32'h6FF, 32'h0, UNL, UNL, 32'h0, 32'h0);
    tick(); idle_in();
    chk_idle("full.reject");
    chk("full.flag2", 32'(full_out), 32'd1);
    tick(); chk_idle("full.stall");
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 5'd3; cdb_alu_data_in = 32'h33;
    for (int c = 0; c < 7; c++) begin
      tick(); idle_in();
      if (branch_busy_out) begin
        hit_pc.push_back(int'(pc_out));
        hit_cyc.push_back(c);
        if (pc_out == 32'h600) chk("inorder.dx", branch_datax_out, 32'h33);
      end
    end
    chk("inorder.count", 32'(hit_pc.size()), 32'd4);
    first = BYP ? 0 : 1;
    for (int k = 0; k < 4 && k < hit_pc.size(); k++) begin
      chk($sformatf("inorder.pc%0d", k), 32'(hit_pc[k]), 32'h600 + 32'(4 * k));
      chk($sformatf("inorder.cyc%0d", k), 32'(hit_cyc[k]), 32'(first + k));
    end
    chk("inorder.full_after", 32'(full_out), 32'd0);
    drive_alloc(6'd7, 32'h610, 32'h0, UNL, UNL, 32'hAA, 32'hBB);
    tick(); idle_in();
    tick();
    chk_out("wrap.issue", 1'b1, 6'd7, 32'h610, 32'h0, 32'hAA, 32'hBB);

    // Flush: two pending entries dropped; alloc and wakeup in the flush cycle
    // are overridden; an already-registered branch is not retracted.
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    drive_alloc(6'd1, 32'h700, 32'h0, 5'd6, UNL, 32'h0, 32'h0); tick();
    drive_alloc(6'd1, 32'h704, 32'h0, 5'd6, UNL, 32'h0, 32'h0); tick();
    idle_in();
    flush_in = 1'b1;
    drive_alloc(6'd2, 32'h7EE, 32'h0, UNL, UNL, 32'h0, 32'h0);
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 5'd6; cdb_alu_data_in = 32'h66;
    tick(); idle_in();
    chk_idle("flush.e0");
    chk("flush.full", 32'(full_out), 32'd0);
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 5'd6; cdb_alu_data_in = 32'h66;
    tick(); idle_in(); chk_idle("flush.e1");
    tick(); chk_idle("flush.e2");
    tick(); chk_idle("flush.e3");
    drive_alloc(6'd3, 32'h710, 32'h4, UNL, UNL, 32'h1, 32'h2);
    tick(); idle_in(); chk_idle("flush.realloc");
    tick();
    chk_out("flush.issue", 1'b1, 6'd3, 32'h710, 32'h4, 32'h1, 32'h2);
    flush_in = 1'b1;
    #1;
    chk("flush.noretract", 32'(branch_busy_out), 32'd1);
    tick(); idle_in(); chk_idle("flush.after");

    // rdy low for three cycles with a ready head; alloc during the stall is
    // ignored.
    drive_alloc(6'd4, 32'h800, 32'h8, UNL, UNL, 32'h1, 32'h2);
    tick(); idle_in(); chk_idle("rdy.alloc");
    for (int k = 0; k < 3; k++) begin
      rdy = 1'b0;
      drive_alloc(6'd5, 32'h8AA, 32'h0, UNL, UNL, 32'h0, 32'h0);
      tick();
      chk_idle($sformatf("rdy.stall%0d", k));
    end
    idle_in();
    tick(); chk_out("rdy.resume", 1'b1, 6'd4, 32'h800, 32'h8, 32'h1, 32'h2);
    tick(); chk_idle("rdy.after");

    // Reset mid-stream: four entries woken by one broadcast, reset asserted
    // while the first one is on the outputs.
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_alloc(6'd0, 32'hA00 + 32'(4 * k), 32'h0, 5'd4, UNL, 32'h0, 32'h0);
      tick();
    end
    idle_in();
    chk("rst.full_before", 32'(full_out), 32'd1);
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 5'd4; cdb_alu_data_in = 32'h44;
    tick(); idle_in();
    tick();
    chk("rst.busy_before", 32'(branch_busy_out), 32'd1);
    chk("rst.pc_before", pc_out, BYP ? 32'hA04 : 32'hA00);
    #2 rst = 1'b1;
    #1;
    chk_idle("rst.async");
    chk("rst.full", 32'(full_out), 32'd0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst.quiet%0d", k), 32'(branch_busy_out), 32'd0);
      chk($sformatf("rst.qfull%0d", k), 32'(full_out), 32'd0);
    end

    // Randomized traffic against the reference model.
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    mq.delete();
    for (int c = 0; c < 2000; c++) begin
      idle_in();
      rdy      = ($urandom_range(9) != 0);
      flush_in = ($urandom_range(39) == 0);
      if ($urandom_range(1) == 1)
        drive_alloc(6'($urandom_range(5)), $urandom, $urandom,
                    ($urandom_range(1) == 1) ? UNL : 5'($urandom_range(1, 7)),
                    ($urandom_range(1) == 1) ? UNL : 5'($urandom_range(1, 7)),
                    $urandom, $urandom);
      t = 5'($urandom_range(1, 7));
      cdb_alu_en_in   = ($urandom_range(2) == 0);
      cdb_alu_tag_in  = t;
      cdb_alu_data_in = $urandom;
      cdb_lsb_en_in   = ($urandom_range(2) == 0);
      cdb_lsb_tag_in  = 5'(((32'(t) + $urandom_range(0, 5)) % 7) + 1);
      cdb_lsb_data_in = $urandom;
      model_step();
      tick();
      chk_out($sformatf("rand%0d", c), m_busy, m_out.op, m_out.pc, m_out.off,
              m_out.dx, m_out.dy);
      chk($sformatf("rand%0d.full", c), 32'(full_out), 32'(mq.size() == 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
